// File: rtl/controller_emulator_if.sv
// Host-side bus of the game-controller emulator: button inputs and latch/shift
// strobes from the host, plus the serial data and status returned to it.
interface controller_emulator_if;
    logic [7:0] buttons_i;
    logic       latch_i;
    logic       ctrl_clk_i;
    logic       serial_no;
    logic       busy_o;
    logic       frame_done_o;

    modport master (
        output buttons_i,
        output latch_i,
        output ctrl_clk_i,
        input  serial_no,
        input  busy_o,
        input  frame_done_o
    );

    modport slave (
        input  buttons_i,
        input  latch_i,
        input  ctrl_clk_i,
        output serial_no,
        output busy_o,
        output frame_done_o
    );
endinterface

// File: rtl/controller_emulator.sv
// Serial game-controller emulator: latches 8 buttons and shifts them out MSB first, active-low.
// Optional stall watchdog is enabled by defining CONTROLLER_EMULATOR_WATCHDOG_EN.
module controller_emulator #(
    parameter int SYNC_STAGES     = 2,
    parameter int WATCHDOG_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    controller_emulator_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    generate
        if (SYNC_STAGES < 2 || WATCHDOG_CYCLES < 1) begin : g_param_check
            $error("controller_emulator: SYNC_STAGES must be >= 2 and WATCHDOG_CYCLES >= 1");
        end
    endgenerate

    // Index 0 is the latch, index 1 the shift clock; both share the same conditioning path.
    logic [1:0] host_in;
    logic [1:0] host_level;
    logic [1:0] host_rise;

    assign host_in = {bus.ctrl_clk_i, bus.latch_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   edge_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg <= '0;
                    edge_reg <= 1'b0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], host_in[gi]};
                    edge_reg <= sync_reg[SYNC_STAGES-1];
                end
            end

            assign host_level[gi] = sync_reg[SYNC_STAGES-1];
            assign host_rise[gi]  = sync_reg[SYNC_STAGES-1] & ~edge_reg;
        end
    endgenerate

    logic latch_level;
    logic ctrl_rise;
    logic unused_latch_rise;

    assign latch_level       = host_level[0];
    assign ctrl_rise         = host_rise[1];
    // The latch acts as a level (it reloads every cycle it is high), so its rise pulse is not needed.
    assign unused_latch_rise = host_rise[0] ^ host_level[1];

    state_t     state_reg, state_next;
    logic [7:0] shreg_reg, shreg_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic       serial_reg, serial_next;
    logic       frame_done_reg, frame_done_next;
    logic       wd_expired;

`ifdef CONTROLLER_EMULATOR_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;

    // Counts idle SHIFT cycles; any edge, latch or state change restarts it from zero.
    always_comb begin
        wd_cnt_next = '0;
        wd_expired  = 1'b0;
        if (state_reg == SHIFT && !latch_level && !ctrl_rise) begin
            if (wd_cnt_reg == WD_W'(WATCHDOG_CYCLES - 1)) begin
                wd_expired = 1'b1;
            end else begin
                wd_cnt_next = wd_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_next      = state_reg;
        shreg_next      = shreg_reg;
        bit_cnt_next    = bit_cnt_reg;
        frame_done_next = 1'b0;

        if (latch_level) begin
            state_next   = LOAD;
            shreg_next   = bus.buttons_i;
            bit_cnt_next = 4'd0;
        end else begin
            case (state_reg)
                LOAD: begin
                    state_next = SHIFT;
                end
                SHIFT: begin
                    if (ctrl_rise) begin
                        shreg_next   = {shreg_reg[6:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            state_next      = DONE;
                            frame_done_next = 1'b1;
                        end
                    end else if (wd_expired) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end

        // Data is driven from the current state so the first bit appears one cycle after LOAD.
        if (state_reg == LOAD || state_reg == SHIFT) begin
            serial_next = ~shreg_reg[7];
        end else begin
            serial_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= 8'd0;
            bit_cnt_reg    <= 4'd0;
            serial_reg     <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            bit_cnt_reg    <= bit_cnt_next;
            serial_reg     <= serial_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign bus.serial_no    = serial_reg;
    assign bus.frame_done_o = frame_done_reg;
    assign bus.busy_o       = (state_reg == LOAD) || (state_reg == SHIFT);

endmodule

// File: tb/tb_controller_emulator.sv
// Self-checking bench for controller_emulator: table-driven frames plus hand-written
// abort, reset, overrun and stall sequences, checked through an expected-bit queue.
module tb_controller_emulator;

    localparam int SYNC = 2;
    localparam int HOLD = 6;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    controller_emulator_if bus ();

    controller_emulator #(
        .SYNC_STAGES    (SYNC),
        .WATCHDOG_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] buttons;
        logic [7:0] exp_serial;
    } vec_t;

    vec_t vecs[5];
    bit   exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    always @(negedge clk) begin
        if (bus.frame_done_o === 1'b1) done_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_ctrl();
        bus.ctrl_clk_i = 1'b1;
        cycles(HOLD);
        bus.ctrl_clk_i = 1'b0;
        cycles(HOLD);
    endtask

    task automatic load_frame(input logic [7:0] btn, input logic [7:0] pat);
        for (int k = 7; k >= 0; k--) exp_q.push_back(pat[k]);
        bus.buttons_i = btn;
        bus.latch_i   = 1'b1;
        cycles(HOLD);
        bus.latch_i   = 1'b0;
        cycles(HOLD);
    endtask

    task automatic shift_bits(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s bit%0d: got serial sample expected none queued", tag, i);
            end else begin
                check($sformatf("%s bit%0d", tag, i), int'(bus.serial_no), int'(exp_q.pop_front()));
            end
            pulse_ctrl();
        end
    endtask

    task automatic check_frame_end(input string tag, input int d0, input int exp_done);
        check({tag, " serial_after"}, int'(bus.serial_no), 1);
        check({tag, " busy_after"}, int'(bus.busy_o), 0);
        check({tag, " done_pulses"}, done_cnt - d0, exp_done);
        $display("frame %s: done_pulses=%0d", tag, done_cnt - d0);
    endtask

    initial begin
        int d0;

        vecs[0] = '{buttons: 8'hA5, exp_serial: 8'h5A};
        vecs[1] = '{buttons: 8'h00, exp_serial: 8'hFF};
        vecs[2] = '{buttons: 8'hFF, exp_serial: 8'h00};
        vecs[3] = '{buttons: 8'h01, exp_serial: 8'hFE};
        vecs[4] = '{buttons: 8'h3C, exp_serial: 8'hC3};

        bus.buttons_i  = 8'h00;
        bus.latch_i    = 1'b0;
        bus.ctrl_clk_i = 1'b0;
        rst            = 1'b1;
        cycles(3);
        check("reset serial", int'(bus.serial_no), 1);
        check("reset busy", int'(bus.busy_o), 0);
        check("reset done", int'(bus.frame_done_o), 0);
        rst = 1'b0;
        cycles(2);

        // Latch-to-output latency is SYNC+2 clocks
        d0 = done_cnt;
        for (int k = 7; k >= 0; k--) exp_q.push_back(k != 7);
        bus.buttons_i = 8'h80;
        bus.latch_i   = 1'b1;
        cycles(SYNC);
        check("latency busy_early", int'(bus.busy_o), 0);
        cycles(1);
        check("latency busy", int'(bus.busy_o), 1);
        check("latency serial_early", int'(bus.serial_no), 1);
        cycles(1);
        check("latency serial", int'(bus.serial_no), 0);
        cycles(HOLD);
        bus.latch_i = 1'b0;
        cycles(HOLD);
        shift_bits(8, "latency");
        check_frame_end("latency", d0, 1);

        for (int v = 0; v < 5; v++) begin
            d0 = done_cnt;
            load_frame(vecs[v].buttons, vecs[v].exp_serial);
            shift_bits(8, $sformatf("vec%0d", v));
            check_frame_end($sformatf("vec%0d", v), d0, 1);
        end

        // Buttons changing mid-frame must not disturb the loaded value
        d0 = done_cnt;
        load_frame(8'h00, 8'hFF);
        bus.buttons_i = 8'hFF;
        shift_bits(8, "hold_btn");
        check_frame_end("hold_btn", d0, 1);

        // Latch reasserted after three bits restarts the frame
        d0 = done_cnt;
        load_frame(8'hC3, 8'h3C);
        shift_bits(3, "abort");
        exp_q.delete();
        load_frame(8'h80, 8'h7F);
        shift_bits(8, "restart");
        check_frame_end("restart", d0, 1);

        // Extra shift clocks after a finished frame
        d0 = done_cnt;
        for (int p = 0; p < 2; p++) begin
            pulse_ctrl();
            check($sformatf("overrun%0d serial", p), int'(bus.serial_no), 1);
        end
        check_frame_end("overrun", d0, 0);

        // Reset in the middle of a frame
        load_frame(8'hA5, 8'h5A);
        shift_bits(4, "pre_rst");
        d0  = done_cnt;
        rst = 1'b1;
        cycles(1);
        check("mid_rst serial", int'(bus.serial_no), 1);
        check("mid_rst busy", int'(bus.busy_o), 0);
        rst = 1'b0;
        exp_q.delete();
        cycles(2);
        check("mid_rst done", done_cnt - d0, 0);
        d0 = done_cnt;
        load_frame(8'hA5, 8'h5A);
        shift_bits(8, "post_rst");
        check_frame_end("post_rst", d0, 1);

        // Host stalls after two bits
        d0 = done_cnt;
        load_frame(8'h3C, 8'hC3);
        shift_bits(2, "stall");
        check("stall busy_before", int'(bus.busy_o), 1);
        cycles(10);
`ifdef CONTROLLER_EMULATOR_WATCHDOG_EN
        check("stall busy_after", int'(bus.busy_o), 0);
        check("stall serial_after", int'(bus.serial_no), 1);
`else
        check("stall busy_after", int'(bus.busy_o), 1);
        check("stall serial_after", int'(bus.serial_no), 0);
`endif
        check("stall done", done_cnt - d0, 0);
        exp_q.delete();
        d0 = done_cnt;
        load_frame(8'h5A, 8'hA5);
        shift_bits(8, "recover");
        check_frame_end("recover", d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controller_emulator.md
CONTROLLER_EMULATOR -- requirements
Module: controller_emulator

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flip-flop stages on each host-driven input (minimum 2).
REQ-002 Parameter WATCHDOG_CYCLES, default 4096: idle clk cycles before an unfinished frame is abandoned (watchdog build only).
REQ-003 Port clk  input  1: single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port buttons_i  input  8: button state, active-high pressed, bit 7 shifted out first.
REQ-006 Port latch_i  input  1: host latch, asynchronous to clk, active-high.
REQ-007 Port ctrl_clk_i  input  1: host shift clock, asynchronous to clk; a rising edge advances one bit.
REQ-008 Port serial_no  output  1: serial button data to host, active-low (low = pressed), registered.
REQ-009 Port busy_o  output  1: high in LOAD or SHIFT.
REQ-010 Port frame_done_o  output  1: one-clk pulse when the 8th bit has been shifted.

Function
REQ-011 latch_i and ctrl_clk_i SHALL each pass through SYNC_STAGES synchronizer flops, then one edge-detect flop; all decisions use the synchronized values only.
REQ-012 States SHALL be IDLE, LOAD, SHIFT, DONE; 8-bit shift register shreg; 4-bit counter bit_cnt (0..8).
REQ-013 Any state, synchronized latch high: next state LOAD, shreg <= buttons_i every cycle, bit_cnt <= 0; latch dominates a simultaneous clock edge.
REQ-014 LOAD, synchronized latch low: next state SHIFT; shreg holds the last value loaded.
REQ-015 SHIFT, ctrl_clk rising edge: shreg <= {shreg[6:0],1'b0}, bit_cnt <= bit_cnt+1; when bit_cnt becomes 8, next state DONE and frame_done_o pulses that cycle.
REQ-016 DONE: hold until latch high (REQ-013); ctrl_clk edges ignored.
REQ-017 IDLE: ctrl_clk edges ignored.
REQ-018 serial_no SHALL be registered: ~shreg[7] in LOAD and SHIFT, 1 in IDLE and DONE; first bit (buttons_i[7]) valid one clk after LOAD is entered.
REQ-019 Latency: input edge to serial_no change SHALL be exactly SYNC_STAGES+2 clk cycles.
REQ-020 Host timing contract: latch_i and ctrl_clk_i levels held at least SYNC_STAGES+2 clk cycles; shorter pulses may be missed without error.
REQ-021 Latch reasserted mid-SHIFT SHALL restart the frame (REQ-013) without frame_done_o.
REQ-022 buttons_i changes outside LOAD SHALL NOT affect the frame in progress.
REQ-023 busy_o SHALL be combinational from state only.

Reset
REQ-024 On rst: state IDLE, shreg 0, bit_cnt 0, synchronizer and edge flops 0, serial_no 1, busy_o 0, frame_done_o 0, watchdog counter 0.
REQ-025 rst mid-frame SHALL abandon the frame; serial_no high the following cycle; no frame_done_o.

Configuration
REQ-026 Macro CONTROLLER_EMULATOR_WATCHDOG_EN.
REQ-027 Defined: a counter counts clk cycles in SHIFT with no ctrl_clk edge, cleared on each edge or state change; reaching WATCHDOG_CYCLES forces IDLE, serial_no 1, no frame_done_o.
REQ-028 Undefined: no watchdog logic; SHIFT waits indefinitely; WATCHDOG_CYCLES unused.

Verification
REQ-029 buttons_i=8'hA5, latch pulse, 8 ctrl_clk pulses -> serial_no samples 0,1,0,1,1,0,1,0 (bit7 first); one frame_done_o pulse; serial_no 1 afterwards.
REQ-030 buttons_i changed to 8'hFF during SHIFT after loading 8'h00 -> all 8 bits read 1 (released).
REQ-031 Latch reasserted after 3 clocks with buttons_i=8'h80 -> serial_no 0 then seven 1s after release; no frame_done_o from the aborted frame.
REQ-032 9th and 10th ctrl_clk pulses after frame -> serial_no stays 1, no extra frame_done_o.
REQ-033 rst asserted after 4 bits -> serial_no 1, busy_o 0 next cycle; new latch+8 clocks completes normally.
REQ-034 WATCHDOG_EN, WATCHDOG_CYCLES=16, stall after 2 bits -> IDLE 16 cycles later, serial_no 1, busy_o 0; without the macro the state stays SHIFT.
